// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALUOp, funct and forwarding selects,
// plus the multiply/divide iteration-counter width helper.
package execute_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;

   localparam logic [1:0] FWD_REG     = 2'b00;
   localparam logic [1:0] FWD_EX_MEM  = 2'b01;
   localparam logic [1:0] FWD_MEM_WB  = 2'b10;
   localparam logic [1:0] FWD_REG_ALT = 2'b11;

   function automatic int md_cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative shift-add multiplier holding HI/LO; one partial product per cycle,
// DATA_W cycles per multiply, signed handled by magnitude multiply plus negate.
module md_unit
   import execute_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   output logic              o_busy,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   localparam int CNT_W = md_cnt_w(DATA_W);

   logic                r_busy;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   r_mcand;
   logic [2*DATA_W-1:0] r_prod;
   logic                r_neg;

   logic [DATA_W-1:0]   w_abs_a;
   logic [DATA_W-1:0]   w_abs_b;
   logic [DATA_W:0]     w_sum;
   logic [2*DATA_W-1:0] w_prod_nxt;
   logic [2*DATA_W-1:0] w_final;

   assign w_abs_a = (i_signed && i_op_a[DATA_W-1]) ? -i_op_a : i_op_a;
   assign w_abs_b = (i_signed && i_op_b[DATA_W-1]) ? -i_op_b : i_op_b;

   // Upper half accumulates the multiplicand when the current multiplier LSB is set.
   assign w_sum      = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign w_prod_nxt = {w_sum, r_prod[DATA_W-1:1]};
   assign w_final    = r_neg ? -w_prod_nxt : w_prod_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
         r_neg   <= 1'b0;
      end else if (r_busy) begin
         r_prod <= w_prod_nxt;
         r_cnt  <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_busy <= 1'b0;
            r_hi   <= w_final[2*DATA_W-1:DATA_W];
            r_lo   <= w_final[DATA_W-1:0];
         end
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_cnt   <= CNT_W'(DATA_W);
         r_mcand <= w_abs_a;
         r_prod  <= {{DATA_W{1'b0}}, w_abs_b};
         r_neg   <= i_signed & (i_op_a[DATA_W-1] ^ i_op_b[DATA_W-1]);
      end
   end

   assign o_busy = r_busy;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage with forwarding muxes, inline ALU and EX/MEM register; mult/multu
// run in md_unit while independent work proceeds, dependent ops stall upstream.
module execute_stage_md
   import execute_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int REG_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ALUSrc,
   input  logic              RegDst,
   input  logic [1:0]        ALUOp,
   input  logic [DATA_W-1:0] registro_1,
   input  logic [DATA_W-1:0] registro_2,
   input  logic [DATA_W-1:0] sign_extend,
   input  logic [ADDR_W-1:0] jump_dest_addr,
   input  logic [REG_W-1:0]  reg_dest_r_type,
   input  logic [REG_W-1:0]  reg_dest_l_type,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [DATA_W-1:0] ex_mem_fwd_data,
   input  logic [DATA_W-1:0] mem_wb_fwd_data,
   input  logic              flush,
   input  logic              MemToReg_in,
   input  logic              RegWrite_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              Branch_in,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] registro_2_out,
   output logic [REG_W-1:0]  reg_dest_out,
   output logic [ADDR_W-1:0] jump_dest_addr_out,
   output logic              zero_signal_out,
   output logic              MemToReg_out,
   output logic              RegWrite_out,
   output logic              MemRead_out,
   output logic              MemWrite_out,
   output logic              Branch_out,
   output logic              stall_out,
   output logic              md_busy
);

   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b_fwd;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu_res;
   logic [DATA_W-1:0] w_hi;
   logic [DATA_W-1:0] w_lo;
   logic [5:0]        w_funct;
   logic              w_is_md;
   logic              w_is_hilo;
   logic              w_md_start;
   logic              w_bubble;

   always_comb begin
      case (fwd_a)
         FWD_EX_MEM: w_op_a = ex_mem_fwd_data;
         FWD_MEM_WB: w_op_a = mem_wb_fwd_data;
         FWD_REG:    w_op_a = registro_1;
         default:    w_op_a = registro_1;
      endcase
      case (fwd_b)
         FWD_EX_MEM: w_op_b_fwd = ex_mem_fwd_data;
         FWD_MEM_WB: w_op_b_fwd = mem_wb_fwd_data;
         FWD_REG:    w_op_b_fwd = registro_2;
         default:    w_op_b_fwd = registro_2;
      endcase
   end

   assign w_op_b    = ALUSrc ? sign_extend : w_op_b_fwd;
   assign w_funct   = sign_extend[5:0];
   assign w_is_md   = (ALUOp == ALUOP_FUNCT) && (w_funct == FN_MULT || w_funct == FN_MULTU);
   assign w_is_hilo = (ALUOp == ALUOP_FUNCT) && (w_funct == FN_MFHI || w_funct == FN_MFLO);

   assign stall_out  = md_busy & (w_is_md | w_is_hilo);
   assign w_md_start = w_is_md & ~md_busy & ~flush;
   // A multiply occupies no EX/MEM slot of its own; results come back via mfhi/mflo.
   assign w_bubble   = flush | stall_out | w_is_md;

   always_comb begin
      w_alu_res = w_op_a + w_op_b;
      case (ALUOp)
         ALUOP_SUB: w_alu_res = w_op_a - w_op_b;
         ALUOP_FUNCT: begin
            case (w_funct)
               FN_ADD:  w_alu_res = w_op_a + w_op_b;
               FN_SUB:  w_alu_res = w_op_a - w_op_b;
               FN_AND:  w_alu_res = w_op_a & w_op_b;
               FN_OR:   w_alu_res = w_op_a | w_op_b;
               FN_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
               FN_MFHI: w_alu_res = w_hi;
               FN_MFLO: w_alu_res = w_lo;
               default: w_alu_res = w_op_a + w_op_b;
            endcase
         end
         ALUOP_RSVD: w_alu_res = w_op_a + w_op_b;
         default:    w_alu_res = w_op_a + w_op_b;
      endcase
   end

   md_unit #(.DATA_W(DATA_W)) u_md (
      .clock    (clock),
      .reset    (reset),
      .i_start  (w_md_start),
      .i_signed (w_funct == FN_MULT),
      .i_op_a   (w_op_a),
      .i_op_b   (w_op_b),
      .o_busy   (md_busy),
      .o_hi     (w_hi),
      .o_lo     (w_lo)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_out         <= '0;
         registro_2_out     <= '0;
         reg_dest_out       <= '0;
         jump_dest_addr_out <= '0;
         zero_signal_out    <= 1'b0;
         MemToReg_out       <= 1'b0;
         RegWrite_out       <= 1'b0;
         MemRead_out        <= 1'b0;
         MemWrite_out       <= 1'b0;
         Branch_out         <= 1'b0;
      end else begin
         result_out         <= w_alu_res;
         registro_2_out     <= w_op_b_fwd;
         reg_dest_out       <= RegDst ? reg_dest_r_type : reg_dest_l_type;
         jump_dest_addr_out <= jump_dest_addr;
         zero_signal_out    <= (w_alu_res == '0);
         MemToReg_out       <= MemToReg_in & ~w_bubble;
         RegWrite_out       <= RegWrite_in & ~w_bubble;
         MemRead_out        <= MemRead_in  & ~w_bubble;
         MemWrite_out       <= MemWrite_in & ~w_bubble;
         Branch_out         <= Branch_in   & ~w_bubble;
      end
   end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: forwarding, ALU ops, flush, stalls,
// signed/unsigned multiply and asynchronous reset mid-multiply.
module tb_execute_stage_md;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 11;
   localparam int REG_W  = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              ALUSrc, RegDst;
   logic [1:0]        ALUOp;
   logic [DATA_W-1:0] registro_1, registro_2, sign_extend;
   logic [ADDR_W-1:0] jump_dest_addr;
   logic [REG_W-1:0]  reg_dest_r_type, reg_dest_l_type;
   logic [1:0]        fwd_a, fwd_b;
   logic [DATA_W-1:0] ex_mem_fwd_data, mem_wb_fwd_data;
   logic              flush;
   logic              MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
   logic [DATA_W-1:0] result_out, registro_2_out;
   logic [REG_W-1:0]  reg_dest_out;
   logic [ADDR_W-1:0] jump_dest_addr_out;
   logic              zero_signal_out;
   logic              MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
   logic              stall_out, md_busy;

   int n_chk  = 0;
   int n_fail = 0;
   int n_cyc;

   always #5 clock = ~clock;

   execute_stage_md #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
      .clock(clock), .reset(reset), .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp),
      .registro_1(registro_1), .registro_2(registro_2), .sign_extend(sign_extend),
      .jump_dest_addr(jump_dest_addr), .reg_dest_r_type(reg_dest_r_type),
      .reg_dest_l_type(reg_dest_l_type), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data), .flush(flush),
      .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
      .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
      .result_out(result_out), .registro_2_out(registro_2_out), .reg_dest_out(reg_dest_out),
      .jump_dest_addr_out(jump_dest_addr_out), .zero_signal_out(zero_signal_out),
      .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
      .MemWrite_out(MemWrite_out), .Branch_out(Branch_out),
      .stall_out(stall_out), .md_busy(md_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      ALUSrc = 0; RegDst = 0; ALUOp = 2'b00;
      registro_1 = '0; registro_2 = '0; sign_extend = '0;
      jump_dest_addr = '0; reg_dest_r_type = '0; reg_dest_l_type = '0;
      fwd_a = 2'b00; fwd_b = 2'b00; ex_mem_fwd_data = '0; mem_wb_fwd_data = '0;
      flush = 0; MemToReg_in = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; Branch_in = 0;
   endtask

   task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      clr();
      ALUOp = 2'b10; sign_extend = {26'd0, f};
      registro_1 = a; registro_2 = b;
      RegWrite_in = 1; RegDst = 1; reg_dest_r_type = 5'd3;
   endtask

   initial begin
      reset = 1;
      clr();
      tick(); tick();
      chk("rst_result", result_out, 0);
      chk("rst_regwrite", RegWrite_out, 0);
      chk("rst_busy", md_busy, 0);
      chk("rst_stall", stall_out, 0);
      reset = 0;

      // forwarding A from EX/MEM: 7 + 3
      rtype(6'h20, 32'd5, 32'd3);
      fwd_a = 2'b01; ex_mem_fwd_data = 32'd7; reg_dest_r_type = 5'd9; jump_dest_addr = 11'h5A5;
      tick();
      chk("fwd_add", result_out, 10);
      chk("fwd_regwrite", RegWrite_out, 1);
      chk("fwd_dest", reg_dest_out, 9);
      chk("fwd_jump", jump_dest_addr_out, 11'h5A5);
      chk("fwd_zero", zero_signal_out, 0);

      // forwarding B from MEM/WB: 150 - 100, store data is forwarded B
      rtype(6'h22, 32'd150, 32'd3);
      fwd_b = 2'b10; mem_wb_fwd_data = 32'd100;
      tick();
      chk("fwdb_sub", result_out, 50);
      chk("fwdb_store", registro_2_out, 100);

      clr(); ALUOp = 2'b01; registro_1 = 32'd9; registro_2 = 32'd9; reg_dest_l_type = 5'd4;
      tick();
      chk("sub_zero_res", result_out, 0);
      chk("sub_zero_flag", zero_signal_out, 1);
      chk("ltype_dest", reg_dest_out, 4);

      rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("slt_neg", result_out, 1);
      rtype(6'h2A, 32'd1, 32'hFFFF_FFFF);
      tick();
      chk("slt_pos", result_out, 0);
      rtype(6'h24, 32'h0000_F0F0, 32'h0000_FF00);
      tick();
      chk("and", result_out, 32'h0000_F000);
      rtype(6'h25, 32'h0000_F0F0, 32'h0000_FF00);
      tick();
      chk("or", result_out, 32'h0000_FFF0);

      // immediate operand: 10 + (-2); store data still the register
      clr(); ALUSrc = 1; registro_1 = 32'd10; registro_2 = 32'h55; sign_extend = 32'hFFFF_FFFE;
      tick();
      chk("imm_add", result_out, 8);
      chk("imm_store", registro_2_out, 32'h55);
      clr(); ALUOp = 2'b11; registro_1 = 32'd2; registro_2 = 32'd3;
      tick();
      chk("rsvd_add", result_out, 5);

      rtype(6'h20, 32'd1, 32'd2); MemWrite_in = 1; flush = 1;
      tick();
      chk("flush_regwrite", RegWrite_out, 0);
      chk("flush_memwrite", MemWrite_out, 0);
      rtype(6'h18, 32'd4, 32'd5); flush = 1;
      tick();
      chk("flush_mult_busy", md_busy, 0);

      // signed multiply -3 x 7 followed by dependent mflo
      rtype(6'h18, 32'hFFFF_FFFD, 32'd7);
      #1;
      chk("mult_issue_nostall", stall_out, 0);
      tick();
      chk("mult_busy", md_busy, 1);
      chk("mult_bubble", RegWrite_out, 0);
      rtype(6'h12, 32'd0, 32'd0);
      n_cyc = 0;
      while (md_busy && n_cyc < 40) begin
         chk("stall_while_busy", stall_out, 1);
         tick();
         n_cyc++;
      end
      chk("mult_latency", n_cyc, 32);
      chk("stall_released", stall_out, 0);
      chk("stall_bubble", RegWrite_out, 0);
      tick();
      chk("mflo_signed", result_out, 32'hFFFF_FFEB);
      chk("mflo_regwrite", RegWrite_out, 1);
      rtype(6'h10, 32'd0, 32'd0);
      tick();
      chk("mfhi_signed", result_out, 32'hFFFF_FFFF);

      // unsigned multiply with independent work overlapping it
      rtype(6'h19, 32'hFFFF_FFFF, 32'd2);
      tick();
      chk("multu_busy", md_busy, 1);
      rtype(6'h20, 32'd3, 32'd4);
      #1;
      chk("indep_nostall", stall_out, 0);
      tick();
      chk("indep_add", result_out, 7);
      chk("indep_regwrite", RegWrite_out, 1);
      rtype(6'h20, 32'd3, 32'd4); flush = 1;
      tick();
      chk("flush_keeps_busy", md_busy, 1);
      chk("flush_bubble", RegWrite_out, 0);
      clr();
      n_cyc = 0;
      while (md_busy && n_cyc < 40) begin
         tick();
         n_cyc++;
      end
      chk("multu_done", md_busy, 0);
      rtype(6'h10, 32'd0, 32'd0);
      tick();
      chk("mfhi_unsigned", result_out, 1);
      rtype(6'h12, 32'd0, 32'd0);
      tick();
      chk("mflo_unsigned", result_out, 32'hFFFF_FFFE);

      // asynchronous reset at busy cycle 10 of a multiply
      rtype(6'h18, 32'd5, 32'd6);
      tick();
      rtype(6'h20, 32'd1, 32'd1);
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_busy", md_busy, 1);
      chk("pre_rst_result", result_out, 2);
      chk("pre_rst_regwrite", RegWrite_out, 1);
      reset = 1;
      #2;
      chk("arst_busy", md_busy, 0);
      chk("arst_result", result_out, 0);
      chk("arst_regwrite", RegWrite_out, 0);
      chk("arst_dest", reg_dest_out, 0);
      tick();
      reset = 0;
      rtype(6'h10, 32'd0, 32'd0);
      tick();
      chk("post_rst_hi", result_out, 0);
      chk("post_rst_busy", md_busy, 0);
      rtype(6'h12, 32'd0, 32'd0);
      tick();
      chk("post_rst_lo", result_out, 0);
      chk("post_rst_regwrite", RegWrite_out, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
